aurora_rx_nfc_buffer: RTL and testbench
=======================================

AURORA_RX_NFC_BUFFER -- requirements
Module: aurora_rx_nfc_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO depth in 64-bit words (power of 2, >=16).
REQ-002 SHALL have parameter XOFF_THRESH, default DEPTH-64, level at which XOFF is requested.
REQ-003 SHALL have parameter XON_THRESH, default DEPTH/4, level at which XON is requested (XON_THRESH < XOFF_THRESH).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, as the ports below.
REQ-005 aurora_userclk  in  1  core user clock; all logic on rising edge.
REQ-006 aurora_rst_n  in  1  asynchronous active-low reset.
REQ-007 aurora_channel_up  in  1  link status from the Aurora core.
REQ-008 s_axis_aurora_tdata  in  64  received word from the core RX stream.
REQ-009 s_axis_aurora_tvalid  in  1  received word valid; there is no ready.
REQ-010 m_axis_tdata  out  64  buffered word to the user.
REQ-011 m_axis_tvalid  out  1  buffered word valid.
REQ-012 m_axis_tready  in  1  user accept.
REQ-013 m_axis_aurora_nfc_tvalid  out  1  NFC request valid to the core.
REQ-014 m_axis_aurora_nfc_tdata  out  16  NFC code.
REQ-015 m_axis_aurora_nfc_tready  in  1  core accepted NFC request.
REQ-016 fifo_level  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 xoff_active  out  1  high from XOFF acceptance until XON acceptance.
REQ-018 overflow  out  1  sticky; a word arrived while the FIFO was full.

Function
REQ-019 Write when s_axis_aurora_tvalid=1 and level<DEPTH; if level==DEPTH, drop the word and set overflow.
REQ-020 FIFO is first-word-fall-through; a word written in cycle N appears on m_axis_tvalid/tdata in cycle N+1 when the FIFO was empty.
REQ-021 Read on m_axis_tvalid & m_axis_tready; m_axis_tdata holds stable while tvalid=1 and tready=0.
REQ-022 fifo_level +1 on write only, -1 on read only, unchanged on a simultaneous write and read, including at full and at empty.
REQ-023 Pointers wrap modulo DEPTH; data order is strictly preserved across wrap.
REQ-024 The NFC FSM has states XON, SEND_XOFF, XOFF, SEND_XON, and resets to XON.
REQ-025 XON -> SEND_XOFF when fifo_level >= XOFF_THRESH and channel_up=1.
REQ-026 SEND_XOFF: nfc_tvalid=1, tdata=NFC_XOFF; hold until tready, then go to XOFF.
REQ-027 XOFF -> SEND_XON when fifo_level <= XON_THRESH.
REQ-028 SEND_XON: nfc_tvalid=1, tdata=NFC_XON; hold until tready, then go to XON.
REQ-029 nfc_tdata is stable while nfc_tvalid=1 and not accepted; nfc_tvalid=0 in XON and XOFF.
REQ-030 xoff_active rises in the cycle after XOFF acceptance and falls in the cycle after XON acceptance.
REQ-031 channel_up=0 in any state forces the FSM to XON next cycle, drops nfc_tvalid and clears xoff_active; FIFO contents are retained and remain drainable.
REQ-032 overflow clears only on reset.

Reset
REQ-033 On aurora_rst_n=0, asynchronously: pointers and fifo_level=0, m_axis_tvalid=0, nfc_tvalid=0, nfc_tdata=0, xoff_active=0, overflow=0, FSM=XON; m_axis_tdata is don't-care.
REQ-034 Reset mid-NFC-request abandons the request; no NFC is reissued after reset until a threshold is crossed again.

Structure
REQ-035 aurora_pkg SHALL hold NFC_XOFF (16'h0100), NFC_XON (16'h0000) and the NFC FSM state enum.
REQ-036 FIFO storage and pointers SHALL be a sub-module aurora_sync_fifo (DEPTH, WIDTH parameters, FWFT, level output); NFC FSM stays in the top.

Verification (DEPTH=16, XOFF_THRESH=12, XON_THRESH=4)
REQ-037 Write 0x1..0x5, tready=1 -> output 0x1..0x5 in order, first one cycle after first write, level returns to 0.
REQ-038 Write 12 words, tready=0 -> one NFC request 0x0100; tready delayed 3 cycles -> tdata stable, xoff_active=1 after accept.
REQ-039 From level 12 in XOFF, drain to 4 -> one NFC request 0x0000; xoff_active=0 after accept; no repeat request.
REQ-040 Write 17 words, tready=0 -> level=16, 17th dropped, overflow=1, first 16 words read back intact.
REQ-041 At level 16, simultaneous write and read for 20 cycles -> level stays 16, no overflow, order preserved across wrap.
REQ-042 channel_up=0 during SEND_XOFF -> nfc_tvalid=0 next cycle, FSM=XON, FIFO data still readable; async reset mid-traffic -> all outputs 0 immediately.

Source files
------------

// File: rtl/aurora_pkg.sv
// aurora_pkg: shared NFC codes and the flow-control FSM state encoding
package aurora_pkg;
  localparam logic [15:0] NFC_XOFF = 16'h0100;
  localparam logic [15:0] NFC_XON = 16'h0000;
  typedef enum logic [1:0] {ST_XON, ST_SEND_XOFF, ST_XOFF, ST_SEND_XON} nfc_state_e;
endpackage

// File: rtl/aurora_sync_fifo.sv
// aurora_sync_fifo: first-word-fall-through synchronous FIFO with occupancy output
// Ports: wr_valid_i/wr_data_i push (no backpressure, wr_drop_o flags a lost word),
//        rd_valid_o/rd_data_o/rd_ready_i pop handshake, level_o occupancy
module aurora_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_valid_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   wr_drop_o,
  output logic                   rd_valid_o,
  output logic [WIDTH-1:0]       rd_data_o,
  input  logic                   rd_ready_i,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic full, wr_en, rd_en;
  assign rd_valid_o = level_q != '0;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  always_comb begin
    full = level_q == LW'(DEPTH);
    rd_en = rd_valid_o & rd_ready_i;
    wr_en = wr_valid_i & (~full | rd_en);
    wr_drop_o = wr_valid_i & full & ~rd_en;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d = level_q + LW'(wr_en) - LW'(rd_en);
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/aurora_rx_nfc_buffer.sv
// aurora_rx_nfc_buffer: Aurora RX elastic buffer issuing XOFF/XON native flow control
// Ports: s_axis_aurora_* RX stream in (no ready), m_axis_* buffered stream out,
//        m_axis_aurora_nfc_* NFC request to the core, fifo_level/xoff_active/overflow status
module aurora_rx_nfc_buffer
  import aurora_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int XOFF_THRESH = DEPTH - 64,
  parameter int XON_THRESH = DEPTH / 4
) (
  input  logic                   aurora_userclk,
  input  logic                   aurora_rst_n,
  input  logic                   aurora_channel_up,
  input  logic [63:0]            s_axis_aurora_tdata,
  input  logic                   s_axis_aurora_tvalid,
  output logic [63:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_aurora_nfc_tvalid,
  output logic [15:0]            m_axis_aurora_nfc_tdata,
  input  logic                   m_axis_aurora_nfc_tready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   xoff_active,
  output logic                   overflow
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] XOFF_L = LW'(XOFF_THRESH);
  localparam logic [LW-1:0] XON_L = LW'(XON_THRESH);
  nfc_state_e state_q, state_d;
  logic overflow_q, overflow_d, drop;
  aurora_sync_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk_i      (aurora_userclk),
    .rst_ni     (aurora_rst_n),
    .wr_valid_i (s_axis_aurora_tvalid),
    .wr_data_i  (s_axis_aurora_tdata),
    .wr_drop_o  (drop),
    .rd_valid_o (m_axis_tvalid),
    .rd_data_o  (m_axis_tdata),
    .rd_ready_i (m_axis_tready),
    .level_o    (fifo_level)
  );
  // losing the link abandons any pending request and restarts from XON
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_XON:       state_d = fifo_level >= XOFF_L ? ST_SEND_XOFF : ST_XON;
      ST_SEND_XOFF: state_d = m_axis_aurora_nfc_tready ? ST_XOFF : ST_SEND_XOFF;
      ST_XOFF:      state_d = fifo_level <= XON_L ? ST_SEND_XON : ST_XOFF;
      ST_SEND_XON:  state_d = m_axis_aurora_nfc_tready ? ST_XON : ST_SEND_XON;
      default:      state_d = ST_XON;
    endcase
    if (!aurora_channel_up) state_d = ST_XON;
    overflow_d = overflow_q | drop;
    m_axis_aurora_nfc_tvalid = state_q == ST_SEND_XOFF || state_q == ST_SEND_XON;
    m_axis_aurora_nfc_tdata = state_q == ST_SEND_XOFF ? NFC_XOFF : NFC_XON;
    xoff_active = state_q == ST_XOFF || state_q == ST_SEND_XON;
  end
  always_ff @(posedge aurora_userclk or negedge aurora_rst_n) begin
    if (!aurora_rst_n) begin
      state_q <= ST_XON;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      overflow_q <= overflow_d;
    end
  end
  assign overflow = overflow_q;
endmodule

// File: tb/tb_aurora_rx_nfc_buffer.sv
// tb_aurora_rx_nfc_buffer: directed table-driven and sequence checks of the NFC RX buffer
module tb_aurora_rx_nfc_buffer;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cu = 1'b1;
  logic s_tv = 1'b0;
  logic [63:0] s_td = '0;
  logic m_tr = 1'b0;
  logic n_tr = 1'b0;
  logic [63:0] m_td;
  logic m_tv, n_tv, xo, ov;
  logic [15:0] n_td;
  logic [4:0] lvl;
  int checks = 0;
  int failures = 0;
  logic [63:0] q[$];
  logic m_ov = 1'b0;
  typedef struct {
    logic wv;
    logic [63:0] wd;
    logic rdy;
    logic nrdy;
    int lvl;
    logic mtv;
    logic [63:0] mtd;
    logic ntv;
    logic [15:0] ntd;
    logic xo;
    logic ov;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  aurora_rx_nfc_buffer #(.DEPTH(DEPTH), .XOFF_THRESH(12), .XON_THRESH(4)) dut (
    .aurora_userclk           (clk),
    .aurora_rst_n             (rst_n),
    .aurora_channel_up        (cu),
    .s_axis_aurora_tdata      (s_td),
    .s_axis_aurora_tvalid     (s_tv),
    .m_axis_tdata             (m_td),
    .m_axis_tvalid            (m_tv),
    .m_axis_tready            (m_tr),
    .m_axis_aurora_nfc_tvalid (n_tv),
    .m_axis_aurora_nfc_tdata  (n_td),
    .m_axis_aurora_nfc_tready (n_tr),
    .fifo_level               (lvl),
    .xoff_active              (xo),
    .overflow                 (ov)
  );
  function automatic vec_t v(input logic wv, input logic [63:0] wd, input logic rdy, input logic nrdy,
                             input int e_lvl, input logic e_mtv, input logic [63:0] e_mtd,
                             input logic e_ntv, input logic [15:0] e_ntd, input logic e_xo, input logic e_ov);
    v.wv = wv; v.wd = wd; v.rdy = rdy; v.nrdy = nrdy;
    v.lvl = e_lvl; v.mtv = e_mtv; v.mtd = e_mtd;
    v.ntv = e_ntv; v.ntd = e_ntd; v.xo = e_xo; v.ov = e_ov;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // reset is asserted between edges; outputs must clear before any clock arrives
  task automatic reset_dut(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, "_level"}, lvl, 0);
    chk({name, "_tvalid"}, m_tv, 0);
    chk({name, "_nfc_tvalid"}, n_tv, 0);
    chk({name, "_nfc_tdata"}, n_td, 0);
    chk({name, "_xoff_active"}, xo, 0);
    chk({name, "_overflow"}, ov, 0);
    q.delete();
    m_ov = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask
  // one cycle of FIFO traffic checked against a queue model of the buffer
  task automatic cyc(input string name, input logic wv, input logic [63:0] wd, input logic rdy);
    s_tv = wv;
    s_td = wd;
    m_tr = rdy;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (wv && q.size() < DEPTH) q.push_back(wd);
    else if (wv) m_ov = 1'b1;
    step;
    chk({name, "_level"}, lvl, q.size());
    chk({name, "_tvalid"}, m_tv, q.size() != 0);
    if (q.size() != 0) chk({name, "_tdata"}, m_td, q[0]);
    chk({name, "_overflow"}, ov, m_ov);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1);
  end
  initial begin
    for (int i = 1; i <= 5; i++) tbl.push_back(v(1, i, 1, 0, 1, 1, i, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++) tbl.push_back(v(1, 64'h100 + k, 0, 0, k + 1, 1, 64'h100, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 0, 0, 0, 12, 1, 64'h100, 1, 16'h0100, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 12, 1, 64'h100, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 12, 1, 64'h100, 0, 0, 1, 0));
    for (int k = 1; k <= 8; k++) tbl.push_back(v(0, 0, 1, 0, 12 - k, 1, 64'h100 + k, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) tbl.push_back(v(0, 0, 0, 0, 4, 1, 64'h108, 1, 16'h0000, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 4, 1, 64'h108, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 0, 0, 0, 4, 1, 64'h108, 0, 0, 0, 0));
    #2;
    reset_dut("rst0");
    foreach (tbl[i]) begin
      s_tv = tbl[i].wv;
      s_td = tbl[i].wd;
      m_tr = tbl[i].rdy;
      n_tr = tbl[i].nrdy;
      step;
      chk($sformatf("row%0d_level", i), lvl, tbl[i].lvl);
      chk($sformatf("row%0d_tvalid", i), m_tv, tbl[i].mtv);
      if (tbl[i].mtv) chk($sformatf("row%0d_tdata", i), m_td, tbl[i].mtd);
      chk($sformatf("row%0d_nfc_tvalid", i), n_tv, tbl[i].ntv);
      if (tbl[i].ntv) chk($sformatf("row%0d_nfc_tdata", i), n_td, tbl[i].ntd);
      chk($sformatf("row%0d_xoff_active", i), xo, tbl[i].xo);
      chk($sformatf("row%0d_overflow", i), ov, tbl[i].ov);
    end
    n_tr = 1'b1;
    reset_dut("rst1");
    for (int k = 0; k < 17; k++) cyc($sformatf("ovf_wr%0d", k), 1, 64'h200 + k, 0);
    for (int k = 0; k < 16; k++) cyc($sformatf("ovf_rd%0d", k), 0, 0, 1);
    cyc("ovf_sticky", 0, 0, 0);
    reset_dut("rst2");
    for (int k = 0; k < 16; k++) cyc($sformatf("full_wr%0d", k), 1, 64'h300 + k, 0);
    for (int k = 0; k < 20; k++) cyc($sformatf("full_rw%0d", k), 1, 64'h400 + k, 1);
    for (int k = 0; k < 16; k++) cyc($sformatf("full_rd%0d", k), 0, 0, 1);
    n_tr = 1'b0;
    reset_dut("rst3");
    for (int k = 0; k < 12; k++) cyc($sformatf("cu_wr%0d", k), 1, 64'h500 + k, 0);
    for (int n = 0; n < 5 && !n_tv; n++) cyc("cu_wait", 0, 0, 0);
    chk("cu_xoff_req_valid", n_tv, 1);
    chk("cu_xoff_req_data", n_td, 16'h0100);
    cu = 1'b0;
    cyc("cu_down", 0, 0, 0);
    chk("cu_down_nfc_tvalid", n_tv, 0);
    chk("cu_down_xoff_active", xo, 0);
    for (int k = 0; k < 3; k++) cyc($sformatf("cu_drain%0d", k), 0, 0, 1);
    chk("cu_drain_nfc_tvalid", n_tv, 0);
    cu = 1'b1;
    for (int k = 0; k < 3; k++) cyc($sformatf("cu_refill%0d", k), 1, 64'h600 + k, 0);
    for (int n = 0; n < 5 && !n_tv; n++) cyc("rst_wait", 1, 64'h700 + n, 0);
    chk("rst_pre_nfc_tvalid", n_tv, 1);
    s_tv = 1'b1;
    m_tr = 1'b1;
    #2;
    reset_dut("rst_mid");
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("post_rst%0d", k), 0, 0, 0);
      chk($sformatf("post_rst%0d_nfc_tvalid", k), n_tv, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
